mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the 16-bit memory bus.
- Master 0 is the RISC-V core; master 1 is the debug/loader port.
- Only one strobe/ready transaction reaches the memory at a time, with round-robin fairness between the masters.
- A watchdog terminates slave transactions that never return ready and flags them as errors.

---
 rtl/mem_bus_arbiter_if.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Memory bus bundle: strobe/ready handshake with address, write data,
// read data and a timeout error flag. The master modport is the side that
// issues requests; the slave modport is the side that completes them.
interface mem_bus_arbiter_if #(
  parameter int ADDRESS_SIZE = 16,
  parameter int DATA_SIZE    = 32
);
  logic                    strobe;
  logic                    writeEnable;
  logic [ADDRESS_SIZE-1:0] address;
  logic [DATA_SIZE-1:0]    dataWrite;
  logic [DATA_SIZE-1:0]    dataRead;
  logic                    ready;
  logic                    error;

  modport master (
    output strobe,
    output writeEnable,
    output address,
    output dataWrite,
    input  dataRead,
    input  ready
  );

  modport slave (
    input  strobe,
    input  writeEnable,
    input  address,
    input  dataWrite,
    output dataRead,
    output ready,
    output error
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave arbiter for the 16-bit memory bus.
// Master 0 is the core, master 1 the debug/loader port. One transaction at a
// time reaches memory; ties are broken round-robin against the last grant.
// A watchdog ends slave accesses that never see ready and flags an error.
//
//   state  | meaning
//   IDLE   | waiting for a strobe; grant decided and request latched here
//   ACCESS | s_strobe high, waiting for s_ready or the watchdog
//   DONE   | one-cycle ready pulse to the granted master
module mem_bus_arbiter #(
  parameter int ADDRESS_SIZE   = 16,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  mem_bus_arbiter_if.slave   m0,
  mem_bus_arbiter_if.slave   m1,
  mem_bus_arbiter_if.master  s,
  output logic               grant,
  output logic               busy
);

  localparam int               CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_grant;
  logic                    r_s_strobe;
  logic                    r_s_we;
  logic [ADDRESS_SIZE-1:0] r_s_addr;
  logic [DATA_SIZE-1:0]    r_s_dw;
  logic [DATA_SIZE-1:0]    r_m0_rd;
  logic [DATA_SIZE-1:0]    r_m1_rd;
  logic                    r_m0_ready;
  logic                    r_m1_ready;
  logic                    r_m0_err;
  logic                    r_m1_err;

  logic                    w_req_any;
  logic                    w_next_grant;
  logic                    w_req_we;
  logic [ADDRESS_SIZE-1:0] w_req_addr;
  logic [DATA_SIZE-1:0]    w_req_dw;
  logic                    w_timeout_hit;
  logic                    w_complete;
  logic [DATA_SIZE-1:0]    w_cpl_data;
  logic                    w_cpl_err;

  // Pick the next owner: a lone requester wins, a tie goes to the master
  // that did not own the previous transaction.
  always_comb begin
    w_req_any    = m0.strobe | m1.strobe;
    w_next_grant = r_grant;
    if (m0.strobe && m1.strobe) begin
      w_next_grant = ~r_grant;
    end else if (m0.strobe) begin
      w_next_grant = 1'b0;
    end else if (m1.strobe) begin
      w_next_grant = 1'b1;
    end
    w_req_we   = w_next_grant ? m1.writeEnable : m0.writeEnable;
    w_req_addr = w_next_grant ? m1.address     : m0.address;
    w_req_dw   = w_next_grant ? m1.dataWrite   : m0.dataWrite;
  end

  // Completion decode; a real s_ready always beats a coincident timeout.
  always_comb begin
    w_timeout_hit = TIMEOUT_EN && (r_cnt == CNT_LAST);
    w_complete    = s.ready || w_timeout_hit;
    w_cpl_data    = s.ready ? s.dataRead : {DATA_SIZE{1'b1}};
    w_cpl_err     = ~s.ready;
  end

  // Watchdog counter: zero outside ACCESS, counts up and stops at the last
  // cycle so it can never wrap within one transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_cnt <= '0;
    end else if (TIMEOUT_EN && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Arbitration FSM with the slave-side request registers and the
  // per-master completion registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= 1'b1;
      r_s_strobe <= 1'b0;
      r_s_we     <= 1'b0;
      r_s_addr   <= '0;
      r_s_dw     <= '0;
      r_m0_rd    <= '0;
      r_m1_rd    <= '0;
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_grant    <= w_next_grant;
            r_s_we     <= w_req_we;
            r_s_addr   <= w_req_addr;
            r_s_dw     <= w_req_dw;
            r_s_strobe <= 1'b1;
            r_state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_complete) begin
            if (r_grant) begin
              r_m1_rd    <= w_cpl_data;
              r_m1_ready <= 1'b1;
              r_m1_err   <= w_cpl_err;
            end else begin
              r_m0_rd    <= w_cpl_data;
              r_m0_ready <= 1'b1;
              r_m0_err   <= w_cpl_err;
            end
            r_s_strobe <= 1'b0;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_m0_ready <= 1'b0;
          r_m1_ready <= 1'b0;
          r_m0_err   <= 1'b0;
          r_m1_err   <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s.strobe      = r_s_strobe;
  assign s.writeEnable = r_s_we;
  assign s.address     = r_s_addr;
  assign s.dataWrite   = r_s_dw;

  assign m0.dataRead = r_m0_rd;
  assign m0.ready    = r_m0_ready;
  assign m0.error    = r_m0_err;
  assign m1.dataRead = r_m1_rd;
  assign m1.ready    = r_m1_ready;
  assign m1.error    = r_m1_err;

  assign grant = r_grant;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push their
// expected slave request and master completion; two monitors pop and compare.
module tb_mem_bus_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clock = 1'b0;
  logic reset;
  logic grant;
  logic busy;

  mem_bus_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) m0_bus ();
  mem_bus_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) m1_bus ();
  mem_bus_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) s_bus ();

  mem_bus_arbiter #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .grant (grant),
    .busy  (busy)
  );

  always #5 clock = ~clock;
  assign s_bus.error = 1'b0;

  typedef struct {bit who; logic [DW-1:0] data; bit err; int issue; int lat;} cpl_t;
  typedef struct {bit who; logic [AW-1:0] addr; bit we; logic [DW-1:0] dw; int dur;} req_t;

  cpl_t cpl_q[$];
  req_t req_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_lat = 1;
  bit   spurious = 1'b0;
  int   acc_cnt = 0;

  always @(posedge clock) cyc++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [DW-1:0] mem_read(logic [AW-1:0] a);
    case (a)
      16'h1234: return 32'hDEADBEEF;
      16'h0100: return 32'h11110100;
      16'h0200: return 32'h22220200;
      default:  return {~a, a};
    endcase
  endfunction

  // Memory model: s_ready on access cycle mem_lat-1 (0 = never).
  always @(negedge clock) begin
    if (s_bus.strobe) begin
      if (mem_lat != 0 && acc_cnt == mem_lat - 1) begin
        s_bus.ready    = 1'b1;
        s_bus.dataRead = mem_read(s_bus.address);
      end else begin
        s_bus.ready    = 1'b0;
        s_bus.dataRead = 32'h0BAD0BAD;
      end
      acc_cnt++;
    end else begin
      s_bus.ready    = spurious;
      s_bus.dataRead = 32'h5A5A5A5A;
      acc_cnt        = 0;
    end
  end

  task automatic check_cpl(bit who, logic [DW-1:0] data, bit err);
    cpl_t e;
    if (cpl_q.size() == 0) begin
      fail_now($sformatf("unexpected_ready m%0d", who));
      return;
    end
    e = cpl_q.pop_front();
    check("cpl_master", 64'(who), 64'(e.who));
    check("cpl_data", 64'(data), 64'(e.data));
    check("cpl_error", 64'(err), 64'(e.err));
    check("cpl_grant", 64'(grant), 64'(who));
    if (e.lat >= 0) check("cpl_latency", 64'(cyc - e.issue), 64'(e.lat));
  endtask

  // Completion monitor.
  always @(negedge clock) begin
    if (m0_bus.ready && m1_bus.ready) fail_now("both_ready");
    if (m0_bus.ready) check_cpl(1'b0, m0_bus.dataRead, m0_bus.error);
    if (m1_bus.ready) check_cpl(1'b1, m1_bus.dataRead, m1_bus.error);
  end

  bit   prev_strobe = 1'b0;
  req_t cur;
  int   dur = 0;

  // Slave-side monitor: request contents at strobe rise, stability while
  // high, and strobe duration at the fall.
  always @(negedge clock) begin
    if (s_bus.strobe && !prev_strobe) begin
      if (req_q.size() == 0) begin
        fail_now("unexpected_strobe");
        cur = '{grant, s_bus.address, s_bus.writeEnable, s_bus.dataWrite, -1};
      end else begin
        cur = req_q.pop_front();
        check("req_addr", 64'(s_bus.address), 64'(cur.addr));
        check("req_we", 64'(s_bus.writeEnable), 64'(cur.we));
        check("req_wdata", 64'(s_bus.dataWrite), 64'(cur.dw));
        check("req_grant", 64'(grant), 64'(cur.who));
        check("req_busy", 64'(busy), 64'd1);
      end
      dur = 1;
    end else if (s_bus.strobe) begin
      dur++;
      check("hold_addr", 64'(s_bus.address), 64'(cur.addr));
      check("hold_we", 64'(s_bus.writeEnable), 64'(cur.we));
      check("hold_wdata", 64'(s_bus.dataWrite), 64'(cur.dw));
    end else if (prev_strobe && cur.dur >= 0) begin
      check("strobe_cycles", 64'(dur), 64'(cur.dur));
    end
    prev_strobe = s_bus.strobe;
  end

  task automatic drive(bit who, bit stb, logic [AW-1:0] a, bit we, logic [DW-1:0] d);
    if (who) begin
      m1_bus.strobe = stb; m1_bus.address = a; m1_bus.writeEnable = we; m1_bus.dataWrite = d;
    end else begin
      m0_bus.strobe = stb; m0_bus.address = a; m0_bus.writeEnable = we; m0_bus.dataWrite = d;
    end
  endtask

  task automatic wait_ready(bit who);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (who ? m1_bus.ready : m0_bus.ready) begin
        if (who) m1_bus.strobe = 1'b0; else m0_bus.strobe = 1'b0;
        return;
      end
    end
    fail_now($sformatf("ready_timeout m%0d", who));
    if (who) m1_bus.strobe = 1'b0; else m0_bus.strobe = 1'b0;
  endtask

  task automatic wait_strobe();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (s_bus.strobe) return;
    end
    fail_now("strobe_timeout");
  endtask

  task automatic single(bit who, logic [AW-1:0] a, bit we, logic [DW-1:0] d, int lat_mem,
                        logic [DW-1:0] exp_data, bit exp_err, int exp_dur, int exp_lat);
    @(posedge clock); #1;
    mem_lat = lat_mem;
    req_q.push_back('{who, a, we, d, exp_dur});
    cpl_q.push_back('{who, exp_data, exp_err, cyc, exp_lat});
    drive(who, 1'b1, a, we, d);
    wait_ready(who);
  endtask

  task automatic master_loop(bit who, int n, logic [AW-1:0] a, bit we, logic [DW-1:0] d);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      drive(who, 1'b1, a, we, d);
      wait_ready(who);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, '0);
    #2;
    check("rst_grant", 64'(grant), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_strobe", 64'(s_bus.strobe), 64'd0);
    check("rst_s_we", 64'(s_bus.writeEnable), 64'd0);
    check("rst_s_addr", 64'(s_bus.address), 64'd0);
    check("rst_s_wdata", 64'(s_bus.dataWrite), 64'd0);
    check("rst_m0_ready", 64'(m0_bus.ready), 64'd0);
    check("rst_m0_error", 64'(m0_bus.error), 64'd0);
    check("rst_m0_rdata", 64'(m0_bus.dataRead), 64'd0);
    check("rst_m1_ready", 64'(m1_bus.ready), 64'd0);
    check("rst_m1_error", 64'(m1_bus.error), 64'd0);
    check("rst_m1_rdata", 64'(m1_bus.dataRead), 64'd0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;

    // Single read, immediate ready: three-cycle transaction.
    single(1'b0, 16'h1234, 1'b0, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1, 2);

    // Write from m1 whose inputs change while the access is in flight.
    @(posedge clock); #1;
    mem_lat = 2;
    req_q.push_back('{1'b1, 16'h00FF, 1'b1, 32'hA5A5A5A5, 2});
    cpl_q.push_back('{1'b1, 32'hFF0000FF, 1'b0, cyc, 3});
    drive(1'b1, 1'b1, 16'h00FF, 1'b1, 32'hA5A5A5A5);
    wait_strobe();
    m1_bus.address     = 16'hBEEF;
    m1_bus.dataWrite   = 32'h0;
    m1_bus.writeEnable = 1'b0;
    wait_ready(1'b1);

    // Memory never answers: watchdog ends it after four access cycles.
    single(1'b0, 16'h0300, 1'b0, 32'h0, 0, 32'hFFFFFFFF, 1'b1, 4, 5);
    single(1'b0, 16'h1234, 1'b0, 32'h0, 1, 32'hDEADBEEF, 1'b0, 1, 2);

    // s_ready on the last watchdog cycle wins over the timeout.
    single(1'b0, 16'h0100, 1'b0, 32'h0, 4, 32'h11110100, 1'b0, 4, 5);

    // s_ready while idle is ignored.
    @(posedge clock); #1;
    spurious = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    spurious = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_s_strobe", 64'(s_bus.strobe), 64'd0);
    check("idle_m0_ready", 64'(m0_bus.ready), 64'd0);

    // Asynchronous reset in the middle of an access.
    @(posedge clock); #1;
    mem_lat = 0;
    req_q.push_back('{1'b0, 16'h0400, 1'b0, 32'h0, -1});
    drive(1'b0, 1'b1, 16'h0400, 1'b0, 32'h0);
    wait_strobe();
    #2 reset = 1'b1;
    #1;
    check("arst_s_strobe", 64'(s_bus.strobe), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_grant", 64'(grant), 64'd1);
    check("arst_m0_ready", 64'(m0_bus.ready), 64'd0);
    m0_bus.strobe = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;

    // Contention straight after reset: m0 first, then strict alternation.
    mem_lat = 2;
    for (int i = 0; i < 2; i++) begin
      req_q.push_back('{1'b0, 16'h0100, 1'b0, 32'h0, 2});
      req_q.push_back('{1'b1, 16'h0200, 1'b1, 32'hCAFE0001, 2});
      cpl_q.push_back('{1'b0, 32'h11110100, 1'b0, 0, -1});
      cpl_q.push_back('{1'b1, 32'h22220200, 1'b0, 0, -1});
    end
    fork
      master_loop(1'b0, 2, 16'h0100, 1'b0, 32'h0);
      master_loop(1'b1, 2, 16'h0200, 1'b1, 32'hCAFE0001);
    join

    repeat (4) @(posedge clock);
    #1;
    check("cpl_queue_empty", 64'(cpl_q.size()), 64'd0);
    check("req_queue_empty", 64'(req_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
